image_filter_mm: RTL and testbench

Parametrised Avalon-MM slave that convolves a KSIZE×KSIZE RGB window with a software-programmable signed kernel and returns one saturated grayscale output pixel. It is the next-generation window filter in the HPS/DMAC image path. Kernel coefficients, shift and abs mode are run-time registers rather than fixed modes. A single time-shared grayscale+MAC datapath iterates over the window.

---
 rtl/image_filter_pkg.sv | 33 +++
 rtl/image_filter_mm_if.sv | 26 ++
 rtl/image_filter_gray_mac.sv | 46 ++++
 rtl/image_filter_mm.sv | 201 ++++++++++++++++++++
 tb/tb_image_filter_mm.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/image_filter_pkg.sv
// image_filter_pkg
//   Shared constants for the image_filter_mm window filter: Avalon-MM
//   register addresses, FSM state encoding, luma weights and CTRL fields.
package image_filter_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    // Register map (word addresses)
    localparam logic [ADDR_W-1:0] PIXEL_BASE  = 6'd0;
    localparam logic [ADDR_W-1:0] COEF_BASE   = 6'd32;
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = 6'd60;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 6'd61;
    localparam logic [ADDR_W-1:0] RESULT_ADDR = 6'd63;

    // FSM state encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MAC    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    // Luma weights, scaled by 256
    localparam int unsigned LUMA_R = 77;
    localparam int unsigned LUMA_G = 150;
    localparam int unsigned LUMA_B = 29;

    // CTRL register layout
    localparam int unsigned CTRL_W          = 6;
    localparam int unsigned CTRL_ABS_BIT    = 0;
    localparam int unsigned CTRL_SHIFT_LSB  = 1;
    localparam int unsigned CTRL_SHIFT_MSB  = 4;
    localparam int unsigned CTRL_BYPASS_BIT = 5;

endpackage

// File: rtl/image_filter_mm_if.sv
// image_filter_mm_if
//   Avalon-MM slave bus of image_filter_mm plus the busy indicator.
//   master: host side (drives address/read/write/writedata)
//   slave : filter side (drives readdata/waitrequest/busy)
interface image_filter_mm_if;
    import image_filter_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic              busy;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest, busy
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest, busy
    );

endinterface

// File: rtl/image_filter_gray_mac.sv
// image_filter_gray_mac
//   Combinational RGB->gray conversion followed by a signed multiply with
//   one kernel coefficient. Time-shared across the window by the top level.
//   pixel       : packed {Bl, G, R}, BIT_PER_PIXEL bits each
//   gray_bypass : use R directly as gray
//   coef        : signed kernel coefficient
//   product     : signed gray * coef, ACC_W wide
module image_filter_gray_mac
    import image_filter_pkg::*;
#(
    parameter int unsigned BIT_PER_PIXEL = 8,
    parameter int unsigned COEF_W        = 8,
    parameter int unsigned ACC_W         = 22
) (
    input  logic [3*BIT_PER_PIXEL-1:0] pixel,
    input  logic                       gray_bypass,
    input  logic signed [COEF_W-1:0]   coef,
    output logic signed [ACC_W-1:0]    product
);

    localparam int unsigned B     = BIT_PER_PIXEL;
    // 256 * (2^B - 1) is the largest weighted sum, so B+8 bits suffice.
    localparam int unsigned SUM_W = B + 8;

    logic [B-1:0]            r, g, bl, gray;
    logic [SUM_W-1:0]        luma_sum;
    logic signed [ACC_W-1:0] gray_s, coef_s;
    logic                    unused_frac;

    always_comb begin
        r        = pixel[B-1:0];
        g        = pixel[2*B-1:B];
        bl       = pixel[3*B-1:2*B];
        luma_sum = SUM_W'(LUMA_R) * SUM_W'(r)
                 + SUM_W'(LUMA_G) * SUM_W'(g)
                 + SUM_W'(LUMA_B) * SUM_W'(bl);
        gray     = gray_bypass ? r : luma_sum[SUM_W-1:8];
        // gray is unsigned: zero-extend; coef is signed: sign-extend
        gray_s   = ACC_W'(gray);
        coef_s   = ACC_W'(coef);
        product  = gray_s * coef_s;
    end

    assign unused_frac = ^luma_sum[7:0];

endmodule

// File: rtl/image_filter_mm.sv
// image_filter_mm
//   Avalon-MM slave convolving a KSIZE x KSIZE RGB window with a
//   programmable signed kernel, producing one saturated gray pixel.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : Avalon-MM slave (address/read/readdata/write/writedata/
//           waitrequest) plus busy
//   A write to the last PIXEL register starts the computation; one
//   gray*coef product is accumulated per cycle, then a FINISH cycle
//   shifts, optionally takes |v|, clamps and stores RESULT.
module image_filter_mm
    import image_filter_pkg::*;
#(
    parameter int unsigned BIT_PER_PIXEL = 8,
    parameter int unsigned KSIZE         = 3,
    parameter int unsigned COEF_W        = 8
) (
    input logic              clk,
    input logic              reset,
    image_filter_mm_if.slave bus
);

    localparam int unsigned B          = BIT_PER_PIXEL;
    localparam int unsigned ACC_W      = BIT_PER_PIXEL + COEF_W + 6;
    localparam int unsigned NUM_PIXELS = KSIZE * KSIZE;
    localparam int unsigned IDX_W      = $clog2(NUM_PIXELS);
    localparam int unsigned PIX_W      = 3 * BIT_PER_PIXEL;
    localparam int unsigned CENTRE     = NUM_PIXELS / 2;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << B) - 1);

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [PIX_W-1:0]        pixel_q [NUM_PIXELS];
    logic [PIX_W-1:0]        pixel_d [NUM_PIXELS];
    logic signed [COEF_W-1:0] coef_q [NUM_PIXELS];
    logic signed [COEF_W-1:0] coef_d [NUM_PIXELS];
    logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
    logic [B-1:0]            result_q, result_d;
    logic                    done_q, done_d;
    logic                    sat_q, sat_d;

    logic                    busy;
    logic                    wr_acc, rd_result_acc;
    logic [ADDR_W-1:0]       pix_off, coef_off;
    logic                    is_pixel, is_coef;
    logic [IDX_W-1:0]        pix_sel, coef_sel;
    logic signed [ACC_W-1:0] product;
    logic signed [ACC_W-1:0] shifted, mag;
    logic [B-1:0]            clamp_val;
    logic                    clamp_sat;
    logic [DATA_W-1:0]       rdata;
    logic                    unused_wdata;

    image_filter_gray_mac #(
        .BIT_PER_PIXEL (BIT_PER_PIXEL),
        .COEF_W        (COEF_W),
        .ACC_W         (ACC_W)
    ) u_gray_mac (
        .pixel       (pixel_q[idx_q]),
        .gray_bypass (ctrl_q[CTRL_BYPASS_BIT]),
        .coef        (coef_q[idx_q]),
        .product     (product)
    );

    assign busy            = (state_q != S_IDLE);
    assign bus.busy        = busy;
    assign bus.waitrequest = (bus.write | (bus.read & (bus.address == RESULT_ADDR))) & busy;
    assign wr_acc          = bus.write & ~busy;
    // A simultaneous read+write is treated as a write only.
    assign rd_result_acc   = bus.read & ~bus.write & ~busy & (bus.address == RESULT_ADDR);
    assign unused_wdata    = ^bus.writedata;

    always_comb begin
        pix_off  = bus.address - PIXEL_BASE;
        coef_off = bus.address - COEF_BASE;
        is_pixel = (pix_off < ADDR_W'(NUM_PIXELS));
        is_coef  = (bus.address >= COEF_BASE) && (coef_off < ADDR_W'(NUM_PIXELS));
        pix_sel  = pix_off[IDX_W-1:0];
        coef_sel = coef_off[IDX_W-1:0];
    end

    // FINISH datapath: arithmetic shift, optional magnitude, clamp to pixel range
    always_comb begin
        shifted = acc_q >>> ctrl_q[CTRL_SHIFT_MSB:CTRL_SHIFT_LSB];
        if (ctrl_q[CTRL_ABS_BIT] && shifted[ACC_W-1]) begin
            mag = -shifted;
        end else begin
            mag = shifted;
        end
        clamp_sat = 1'b0;
        if (mag[ACC_W-1]) begin
            clamp_val = '0;
            clamp_sat = 1'b1;
        end else if (mag > PIX_MAX) begin
            clamp_val = '1;
            clamp_sat = 1'b1;
        end else begin
            clamp_val = mag[B-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        pixel_d  = pixel_q;
        coef_d   = coef_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        done_d   = done_q;
        sat_d    = sat_q;

        if (rd_result_acc) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_acc) begin
                    if (is_pixel) begin
                        pixel_d[pix_sel] = bus.writedata[PIX_W-1:0];
                        if (pix_sel == IDX_W'(NUM_PIXELS - 1)) begin
                            state_d = S_MAC;
                            idx_d   = '0;
                            acc_d   = '0;
                            done_d  = 1'b0;
                            sat_d   = 1'b0;
                        end
                    end else if (is_coef) begin
                        coef_d[coef_sel] = bus.writedata[COEF_W-1:0];
                    end else if (bus.address == CTRL_ADDR) begin
                        ctrl_d = bus.writedata[CTRL_W-1:0];
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + product;
                if (idx_q == IDX_W'(NUM_PIXELS - 1)) begin
                    idx_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_FINISH: begin
                result_d = clamp_val;
                sat_d    = clamp_sat;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (bus.read && !bus.write) begin
            if (is_pixel) begin
                rdata = DATA_W'(pixel_q[pix_sel]);
            end else if (is_coef) begin
                rdata = DATA_W'(coef_q[coef_sel]);
            end else if (bus.address == CTRL_ADDR) begin
                rdata = DATA_W'(ctrl_q);
            end else if (bus.address == STATUS_ADDR) begin
                rdata = {29'd0, sat_q, done_q, busy};
            end else if (bus.address == RESULT_ADDR) begin
                rdata = DATA_W'(result_q);
            end
        end
    end

    assign bus.readdata = rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
                pixel_q[i] <= '0;
                coef_q[i]  <= (i == CENTRE) ? COEF_W'(1) : '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            pixel_q  <= pixel_d;
            coef_q   <= coef_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_image_filter_mm.sv
// tb_image_filter_mm
//   Directed bench for image_filter_mm: a KSIZE=3/B=8 instance and a
//   KSIZE=5/B=10 instance share one set of host strobes, steered by sel.
module tb_image_filter_mm;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [5:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] rdata_m;
    logic        wait_m;
    logic        busy_m;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    image_filter_mm_if bus3 ();
    image_filter_mm_if bus5 ();

    assign bus3.address   = address;
    assign bus3.writedata = writedata;
    assign bus3.read      = read  & ~sel;
    assign bus3.write     = write & ~sel;
    assign bus5.address   = address;
    assign bus5.writedata = writedata;
    assign bus5.read      = read  & sel;
    assign bus5.write     = write & sel;

    assign rdata_m = sel ? bus5.readdata    : bus3.readdata;
    assign wait_m  = sel ? bus5.waitrequest : bus3.waitrequest;
    assign busy_m  = sel ? bus5.busy        : bus3.busy;

    image_filter_mm #(.BIT_PER_PIXEL(8), .KSIZE(3), .COEF_W(8)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    image_filter_mm #(.BIT_PER_PIXEL(10), .KSIZE(5), .COEF_W(8)) dut5 (
        .clk(clk), .reset(reset), .bus(bus5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, output int stalls);
        int n = 0;
        address = a; writedata = d; write = 1'b1;
        #1;
        while (wait_m && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        if (wait_m) chk("wr_stall_timeout", {31'd0, wait_m}, 32'd0);
        @(posedge clk); #1;
        write = 1'b0;
        stalls = n;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        int s;
        bus_write(a, d, s);
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output int stalls);
        int n = 0;
        address = a; read = 1'b1;
        #1;
        while (wait_m && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        if (wait_m) chk("rd_stall_timeout", {31'd0, wait_m}, 32'd0);
        d = rdata_m;
        @(posedge clk); #1;
        read = 1'b0;
        stalls = n;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int s;
        bus_read(a, d, s);
        chk(tag, d, exp);
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy_m && cnt < 500) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("idle_reached", {31'd0, busy_m}, 32'd0);
    endtask

    function automatic logic [31:0] sobel_pix(input int i, input bit mirror);
        int col = i % 3;
        if (mirror ? (col == 0) : (col == 2)) return 32'h00FF_FFFF;
        return 32'd0;
    endfunction

    task automatic sobel_load(input bit mirror, input logic [31:0] ctrl);
        wr(6'd60, ctrl);
        for (int i = 0; i < 8; i++) wr(6'(i), sobel_pix(i, mirror));
    endtask

    task automatic sobel_run(input string tag, input bit mirror, input logic [31:0] ctrl,
                             input logic [31:0] exp_res, input logic [31:0] exp_stat);
        int c;
        sobel_load(mirror, ctrl);
        wr(6'd8, sobel_pix(8, mirror));
        wait_idle(c);
        rd_chk({tag, "_status"}, 6'd61, exp_stat);
        rd_chk({tag, "_result"}, 6'd63, exp_res);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          st;
        logic [31:0] d;
        int          sobel_k [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};

        reset = 1'b1; sel = 1'b0;
        address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_in_reset", {31'd0, busy_m}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_rdata_noread", rdata_m, 32'd0);
        chk("rst_wait", {31'd0, wait_m}, 32'd0);
        chk("rst_busy", {31'd0, busy_m}, 32'd0);
        rd_chk("rst_coef_centre", 6'd36, 32'd1);
        rd_chk("rst_coef0", 6'd32, 32'd0);
        rd_chk("rst_ctrl", 6'd60, 32'd0);
        rd_chk("rst_status", 6'd61, 32'd0);
        rd_chk("rst_result", 6'd63, 32'd0);

        // Identity kernel: gray(200,100,50) = 31850 >> 8 = 124
        wr(6'd4, 32'h0032_64C8);
        wr(6'd8, 32'd0);
        wait_idle(cnt);
        chk("id_busy_cycles", cnt, 32'd10);
        rd_chk("id_status", 6'd61, 32'd2);
        rd_chk("id_result", 6'd63, 32'd124);
        rd_chk("id_status_after_rd", 6'd61, 32'd0);
        rd_chk("id_pixel4", 6'd4, 32'h0032_64C8);

        // Simultaneous read+write: write serviced, readdata 0
        address = 6'd60; writedata = 32'd6; read = 1'b1; write = 1'b1;
        #1;
        chk("rw_rdata", rdata_m, 32'd0);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        rd_chk("rw_ctrl", 6'd60, 32'd6);
        rd_chk("unmapped_rd", 6'd50, 32'd0);
        wr(6'd61, 32'd7);
        rd_chk("status_ro", 6'd61, 32'd0);
        wr(6'd63, 32'd5);
        rd_chk("result_ro", 6'd63, 32'd124);

        // Sobel-X kernel
        for (int i = 0; i < 9; i++) wr(6'(32 + i), 32'(sobel_k[i]));
        rd_chk("coef3_sext", 6'd35, 32'hFFFF_FFFE);
        rd_chk("coef5", 6'd37, 32'd2);
        sobel_run("sx_sh2",    1'b0, 32'd4, 32'd255, 32'd2);
        sobel_run("sx_sh0",    1'b0, 32'd0, 32'd255, 32'd6);
        sobel_run("sxm_noabs", 1'b1, 32'd4, 32'd0,   32'd6);
        sobel_run("sxm_abs",   1'b1, 32'd5, 32'd255, 32'd2);

        // RESULT read issued one cycle after trigger stalls 9 cycles
        sobel_load(1'b0, 32'd4);
        wr(6'd8, sobel_pix(8, 1'b0));
        bus_read(6'd61, d, st);
        chk("busy_status", d, 32'd1);
        chk("busy_status_nostall", st, 32'd0);
        bus_read(6'd63, d, st);
        chk("res_rd_stalls", st, 32'd9);
        chk("res_rd_data", d, 32'd255);
        rd_chk("res_rd_done_clr", 6'd61, 32'd0);

        // PIXEL write during busy accepted in the first IDLE cycle
        wr(6'd8, sobel_pix(8, 1'b0));
        bus_write(6'd0, 32'h0012_3456, st);
        chk("pix_wr_stalls", st, 32'd10);
        rd_chk("pix_wr_data", 6'd0, 32'h0012_3456);
        rd_chk("pix_wr_status", 6'd61, 32'd2);
        rd_chk("pix_wr_result", 6'd63, 32'd255);

        // Reset in the middle of MAC (idx = 4)
        wr(6'd8, sobel_pix(8, 1'b0));
        repeat (4) @(posedge clk);
        #1;
        chk("mid_idx", 32'(dut3.idx_q), 32'd4);
        chk("mid_busy", {31'd0, busy_m}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy_m}, 32'd0);
        chk("arst_acc", 32'(dut3.acc_q), 32'd0);
        chk("arst_idx", 32'(dut3.idx_q), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rd_chk("arst_result", 6'd63, 32'd0);
        rd_chk("arst_status", 6'd61, 32'd0);
        rd_chk("arst_ctrl", 6'd60, 32'd0);
        rd_chk("arst_coef_centre", 6'd36, 32'd1);
        rd_chk("arst_coef0", 6'd32, 32'd0);
        rd_chk("arst_coef5", 6'd37, 32'd0);
        rd_chk("arst_pixel2", 6'd2, 32'd0);

        // KSIZE=5, B=10, gray bypass, all-ones kernel, R=1023
        sel = 1'b1;
        #1;
        wr(6'd60, 32'd32);
        for (int i = 0; i < 25; i++) wr(6'(32 + i), 32'd1);
        for (int i = 0; i < 24; i++) wr(6'(i), 32'h0000_03FF);
        wr(6'd24, 32'h0000_03FF);
        wait_idle(cnt);
        chk("k5_busy_cycles", cnt, 32'd26);
        chk("k5_acc_sh0", 32'(dut5.acc_q), 32'd25575);
        rd_chk("k5_sh0_status", 6'd61, 32'd6);
        rd_chk("k5_sh0_result", 6'd63, 32'd1023);
        wr(6'd60, 32'd40);
        wr(6'd24, 32'h0000_03FF);
        wait_idle(cnt);
        chk("k5_acc_sh4", 32'(dut5.acc_q), 32'd25575);
        rd_chk("k5_sh4_status", 6'd61, 32'd6);
        rd_chk("k5_sh4_result", 6'd63, 32'd1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
